// File: rtl/top_layer_pkg.sv
// Shared widths, FSM state type and sizing helper for the top_layer shift-add multiplier.
package top_layer_pkg;

  localparam int DEF_M_BITS = 12;
  localparam int DEF_N_BITS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Width of a counter that must reach n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Operand shift registers, conditional adder and accumulator of the shift-add multiplier.
module mult_datapath
  import top_layer_pkg::*;
#(
  parameter int M_BITS = DEF_M_BITS,
  parameter int N_BITS = DEF_N_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_i,
  input  logic                     step_i,
  input  logic [M_BITS-1:0]        mpd_i,
  input  logic [N_BITS-1:0]        mpr_i,
  output logic [M_BITS+N_BITS-1:0] acc_next_o
);

  localparam int P_BITS = M_BITS + N_BITS;

  logic [P_BITS-1:0] mcand_q, mcand_d;
  logic [N_BITS-1:0] mplier_q, mplier_d;
  logic [P_BITS-1:0] acc_q, acc_d;
  logic [P_BITS-1:0] addend;

  // Full product width on both operands of the adder, so no carry is lost.
  assign addend = mplier_q[0] ? mcand_q : '0;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (load_i) begin
      mcand_d  = P_BITS'(mpd_i);
      mplier_d = mpr_i;
      acc_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_q + addend;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // The top latches the post-step value so prod is final on the last RUN edge.
  assign acc_next_o = acc_d;

endmodule

// File: rtl/top_layer.sv
// Sequential shift-add multiplier: FSM and bit counter around mult_datapath.
// Optional one-cycle done pulse when TOP_LAYER_DONE_PULSE_EN is defined.
module top_layer
  import top_layer_pkg::*;
#(
  parameter int M_BITS = DEF_M_BITS,
  parameter int N_BITS = DEF_N_BITS
) (
  input  logic [M_BITS-1:0]        mpd,
  input  logic [N_BITS-1:0]        mpr,
  input  logic                     start,
  input  logic                     clk,
  output logic                     busy,
  output logic [M_BITS+N_BITS-1:0] prod,
  input  logic                     rst
`ifdef TOP_LAYER_DONE_PULSE_EN
  ,
  output logic                     done
`endif
);

  localparam int          P_BITS = M_BITS + N_BITS;
  localparam int          CNT_W  = cnt_width(N_BITS);
  localparam [CNT_W-1:0]  LAST   = CNT_W'(N_BITS - 1);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [P_BITS-1:0]  prod_q;
  logic [P_BITS-1:0]  acc_next;
  logic               load;
  logic               step;

  assign load = (state_q == IDLE) && start;
  assign step = (state_q == RUN);

  mult_datapath #(
    .M_BITS (M_BITS),
    .N_BITS (N_BITS)
  ) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .step_i     (step),
    .mpd_i      (mpd),
    .mpr_i      (mpr),
    .acc_next_o (acc_next)
  );

`ifdef TOP_LAYER_DONE_PULSE_EN
  logic done_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      prod_q  <= '0;
`ifdef TOP_LAYER_DONE_PULSE_EN
      done_q  <= 1'b0;
`endif
    end else begin
`ifdef TOP_LAYER_DONE_PULSE_EN
      done_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          // start is deliberately not looked at here; requests during RUN are dropped.
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            prod_q  <= acc_next;
`ifdef TOP_LAYER_DONE_PULSE_EN
            done_q  <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign prod = prod_q;
`ifdef TOP_LAYER_DONE_PULSE_EN
  assign done = done_q;
`endif

endmodule

// File: tb/tb_top_layer.sv
// Directed bench for top_layer: expected products queued at launch, checked at completion.
module tb_top_layer;

  localparam int M = 12;
  localparam int N = 8;
  localparam int P = M + N;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [M-1:0] mpd;
  logic [N-1:0] mpr;
  logic         busy;
  logic [P-1:0] prod;
`ifdef TOP_LAYER_DONE_PULSE_EN
  logic         done;
`endif

  int total  = 0;
  int passed = 0;
  int fails  = 0;
  logic [P-1:0] sb[$];

  top_layer #(.M_BITS(M), .N_BITS(N)) dut (
    .mpd   (mpd),
    .mpr   (mpr),
    .start (start),
    .clk   (clk),
    .busy  (busy),
    .prod  (prod),
    .rst   (rst)
`ifdef TOP_LAYER_DONE_PULSE_EN
    ,
    .done  (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [P-1:0] model(input logic [M-1:0] a, input logic [N-1:0] b);
    logic [P-1:0] wa;
    logic [P-1:0] wb;
    wa = P'(a);
    wb = P'(b);
    return wa * wb;
  endfunction

  // Drive a one-cycle start pulse; returns at the negedge after the launch edge.
  task automatic launch(input logic [M-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    mpd   = a;
    mpr   = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the launch edge. ign>0 pulses a stray start at busy
  // cycle ign; scramble changes the operand inputs every busy cycle.
  task automatic wait_done(input string tag, input int ign, input bit scramble);
    int n;
    logic [P-1:0] prev;
    logic [P-1:0] exp;
    n    = 0;
    prev = prod;
    check({tag, " busy_rise"}, 32'(busy), 32'd1);
    while (busy === 1'b1 && n < 40) begin
      n++;
      check({tag, " prod_hold"}, 32'(prod), 32'(prev));
      if (ign != 0 && n == ign) begin
        start = 1'b1;
        mpd   = M'($urandom);
        mpr   = N'($urandom);
      end else if (ign != 0 && n == ign + 1) begin
        start = 1'b0;
      end
      if (scramble) begin
        mpd = M'($urandom);
        mpr = N'($urandom);
      end
      @(negedge clk);
    end
    check({tag, " busy_len"}, 32'(n), 32'(N));
    exp = sb.pop_front();
    check({tag, " prod"}, 32'(prod), 32'(exp));
    $display("op %s: prod=0x%0h expected=0x%0h busy_cycles=%0d", tag, prod, exp, n);
`ifdef TOP_LAYER_DONE_PULSE_EN
    check({tag, " done_hi"}, 32'(done), 32'd1);
`endif
    @(negedge clk);
`ifdef TOP_LAYER_DONE_PULSE_EN
    check({tag, " done_lo"}, 32'(done), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    mpd   = '0;
    mpr   = '0;
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset prod", 32'(prod), 32'd0);
`ifdef TOP_LAYER_DONE_PULSE_EN
    check("reset done", 32'(done), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    launch(12'hFFF, 8'hFF);
    wait_done("max", 0, 1'b0);

    // start held high: second operation launches on the first IDLE edge after completion
    @(negedge clk);
    mpd   = 12'h7DF;
    mpr   = 8'h77;
    start = 1'b1;
    sb.push_back(model(12'h7DF, 8'h77));
    @(negedge clk);
    mpd = 12'h6DD;
    mpr = 8'hFF;
    sb.push_back(model(12'h6DD, 8'hFF));
    wait_done("b2b1", 0, 1'b0);
    start = 1'b0;
    wait_done("b2b2_ignored_start", 3, 1'b0);

    launch(12'h8B7, 8'h1F);
    wait_done("8b7x1f", 0, 1'b0);
    launch(12'h000, 8'h00);
    wait_done("zero", 0, 1'b0);
    launch(12'hAAB, 8'hDF);
    wait_done("aabxdf_scramble", 0, 1'b1);

    // abort at busy cycle 4
    launch(12'h123, 8'h45);
    void'(sb.pop_back());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort prod", 32'(prod), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_abort busy", 32'(busy), 32'd0);
      check("post_abort prod", 32'(prod), 32'd0);
`ifdef TOP_LAYER_DONE_PULSE_EN
      check("post_abort done", 32'(done), 32'd0);
`endif
    end
    launch(12'hFFF, 8'hFF);
    wait_done("after_abort", 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      launch(M'($urandom), N'($urandom));
      wait_done("random", (i % 2 == 0) ? 2 : 0, 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/top_layer.md
TOP_LAYER -- requirements
Module: top_layer

Interface
REQ-001 The block SHALL take parameter M_BITS, default 12, as the multiplicand width.
REQ-002 The block SHALL take parameter N_BITS, default 8, as the multiplier width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port mpd, input, M_BITS bits: unsigned multiplicand.
REQ-006 The block SHALL have port mpr, input, N_BITS bits: unsigned multiplier.
REQ-007 The block SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-008 The block SHALL have port busy, output, 1 bit: a multiplication is in progress.
REQ-009 The block SHALL have port prod, output, M_BITS+N_BITS bits: unsigned product of the last completed operation.
REQ-010 Ports SHALL be ordered mpd, mpr, start, clk, busy, prod, rst, so positional instantiation of the first six remains valid.

Function
REQ-011 The block SHALL be a sequential shift-add multiplier with two states, IDLE and RUN.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL capture mpd and mpr, clear the accumulator and the bit counter, and enter RUN.
REQ-013 In IDLE with start=0, the block SHALL remain in IDLE; prod SHALL hold its value.
REQ-014 In RUN, each cycle SHALL process one multiplier bit, LSB first: if the bit is 1, the shifted multiplicand is added to the accumulator; then the multiplicand shifts left and the multiplier shifts right.
REQ-015 The accumulator and the shifted multiplicand SHALL be M_BITS+N_BITS wide, so no overflow or truncation can occur.
REQ-016 After exactly N_BITS RUN cycles, the block SHALL write the accumulator to prod and return to IDLE in the same edge.
REQ-017 busy SHALL be 1 exactly while in RUN: it rises after the start-sampling edge, lasts N_BITS cycles, and falls on the edge that updates prod.
REQ-018 start asserted while in RUN SHALL be ignored; that request is not queued.
REQ-019 start held high continuously SHALL launch a new operation on the first edge in IDLE after completion, using the mpd and mpr values present at that edge.
REQ-020 mpd and mpr changes during RUN SHALL NOT affect the result in progress.
REQ-021 prod SHALL change only at operation completion or reset.
REQ-022 Zero operands SHALL still take the full N_BITS cycles; there is no early termination.

Reset
REQ-023 While rst=1, the block SHALL be in IDLE with busy=0, prod=0, and the accumulator, operand registers and counter cleared, independent of clk.
REQ-024 rst asserted during RUN SHALL abort the operation with no prod update; after release the block SHALL wait in IDLE for start.

Configuration
REQ-025 With TOP_LAYER_DONE_PULSE_EN defined, the block SHALL add output done (1 bit, appended after rst), high for exactly one cycle in the cycle after prod is updated, and reset to 0.
REQ-026 Without TOP_LAYER_DONE_PULSE_EN, the block SHALL have no done port, and all other behaviour SHALL be identical.

Structure
REQ-027 Package top_layer_pkg SHALL hold the default widths (M_BITS=12, N_BITS=8) and the state enum (IDLE, RUN).
REQ-028 The datapath (operand shift registers, adder, accumulator) SHALL be one sub-module, mult_datapath; top_layer SHALL hold the FSM and counter.

Verification
REQ-029 mpd=0xFFF, mpr=0xFF, start pulse -> busy high for 8 cycles, then prod=0xFEF01 (1044225).
REQ-030 Back-to-back: 0x7DF x 0x77 -> 239785, then 0x6DD x 0xFF -> 448035; a start during busy is ignored and prod is unchanged until that operation completes.
REQ-031 0x8B7 x 0x1F -> 69161; 0x000 x 0x00 -> 0 after 8 busy cycles; 0xAAB x 0xDF -> 609013.
REQ-032 rst asserted at busy cycle 4 -> busy=0 and prod=0 immediately; the next start yields the correct product.
REQ-033 mpd and mpr changed mid-operation -> the result still uses the values captured at start.
REQ-034 With TOP_LAYER_DONE_PULSE_EN defined, done is high for exactly one cycle per completed operation, and is never asserted after an aborted one.
